axi_dma_scheduler: RTL and testbench

- Sequences all external-memory traffic for the accelerator. Arbitrates between a read requester (IFM/weight fetch) and a write requester (OFM write-back) for the single AXI master interface.
- Splits each accepted transfer into AXI-legal bursts: at most MAX_BURST beats, never crossing a 4 KB boundary.
- Issues one burst command at a time to the AXI master interface and reports transfer completion to each requester.

---
 rtl/axi_dma_scheduler_if.sv | 45 ++++
 rtl/axi_dma_scheduler.sv | 148 ++++++++++++++
 tb/tb_axi_dma_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_scheduler_if.sv
// Request, burst-command and completion signals between the DMA scheduler,
// its two requesters and the AXI master interface.
interface axi_dma_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned XFER_WIDTH = 20
);
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic [XFER_WIDTH-1:0] rd_req_beats;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic [XFER_WIDTH-1:0] wr_req_beats;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_is_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  burst_done;
    logic                  rd_done;
    logic                  wr_done;
    logic                  busy;

    // Scheduler side
    modport master (
        input  rd_req_valid, rd_req_addr, rd_req_beats,
        input  wr_req_valid, wr_req_addr, wr_req_beats,
        input  cmd_ready, burst_done,
        output rd_req_ready, wr_req_ready,
        output cmd_valid, cmd_is_write, cmd_addr, cmd_len,
        output rd_done, wr_done, busy
    );

    // Requester / AXI master-interface side
    modport slave (
        output rd_req_valid, rd_req_addr, rd_req_beats,
        output wr_req_valid, wr_req_addr, wr_req_beats,
        output cmd_ready, burst_done,
        input  rd_req_ready, wr_req_ready,
        input  cmd_valid, cmd_is_write, cmd_addr, cmd_len,
        input  rd_done, wr_done, busy
    );
endinterface

// File: rtl/axi_dma_scheduler.sv
// Round-robin read/write transfer scheduler: splits each accepted transfer into
// AXI bursts (<= MAX_BURST beats, no 4 KB crossing), one burst outstanding at a time.
module axi_dma_scheduler #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned MAX_BURST      = 256,
    parameter int unsigned BYTES_PER_BEAT = 32,
    parameter int unsigned XFER_WIDTH     = 20
) (
    input logic                 clk,
    input logic                 rst_n,
    axi_dma_scheduler_if.master bus
);
    localparam int unsigned BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
    localparam int unsigned PAGE_BEATS = 4096 / BYTES_PER_BEAT;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XFER_WIDTH-1:0] rem_q, rem_d;
    logic [XFER_WIDTH-1:0] burst_q, burst_d;
    logic [XFER_WIDTH-1:0] page_left;
    logic                  dir_q, dir_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rd_grant, wr_grant;

    logic                  cmd_valid_q;
    logic                  cmd_is_write_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [LEN_WIDTH-1:0]  cmd_len_q;
    logic                  rd_done_q;
    logic                  wr_done_q;
    logic                  busy_q;

    // Arbitration: a lone requester wins, a tie goes to the side not granted last
    always_comb begin
        rd_grant = (state_q == IDLE) && bus.rd_req_valid && (!bus.wr_req_valid || last_grant_q);
        wr_grant = (state_q == IDLE) && bus.wr_req_valid && (!bus.rd_req_valid || !last_grant_q);
    end

    // Next state, transfer bookkeeping and size of the burst about to be issued
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        last_grant_d = last_grant_q;
        page_left    = '0;
        burst_d      = '0;

        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    addr_d       = bus.rd_req_addr & ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);
                    rem_d        = bus.rd_req_beats;
                    dir_d        = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = (rem_d == '0) ? FINISH : ISSUE;
                end else if (wr_grant) begin
                    addr_d       = bus.wr_req_addr & ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);
                    rem_d        = bus.wr_req_beats;
                    dir_d        = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = (rem_d == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.burst_done) begin
                    addr_d  = addr_q + (ADDR_WIDTH'(burst_q) << BEAT_SHIFT);
                    rem_d   = rem_q - burst_q;
                    state_d = (rem_d == '0) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Beats left before the next 4 KB page; always >= 1 for an aligned address
        page_left = XFER_WIDTH'(PAGE_BEATS) - XFER_WIDTH'(addr_d[11:BEAT_SHIFT]);
        burst_d   = rem_d;
        if (burst_d > XFER_WIDTH'(MAX_BURST)) begin
            burst_d = XFER_WIDTH'(MAX_BURST);
        end
        if (burst_d > page_left) begin
            burst_d = page_left;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            burst_q        <= '0;
            dir_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            cmd_valid_q    <= 1'b0;
            cmd_is_write_q <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_len_q      <= '0;
            rd_done_q      <= 1'b0;
            wr_done_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            last_grant_q <= last_grant_d;
            cmd_valid_q  <= (state_d == ISSUE);
            // Command fields load only on entry to ISSUE so they hold during backpressure
            if ((state_d == ISSUE) && (state_q != ISSUE)) begin
                cmd_addr_q     <= addr_d;
                cmd_len_q      <= LEN_WIDTH'(burst_d - XFER_WIDTH'(1));
                cmd_is_write_q <= dir_d;
                burst_q        <= burst_d;
            end
            rd_done_q <= (state_q == FINISH) && !dir_q;
            wr_done_q <= (state_q == FINISH) && dir_q;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.rd_req_ready = rd_grant;
    assign bus.wr_req_ready = wr_grant;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_is_write = cmd_is_write_q;
    assign bus.cmd_addr     = cmd_addr_q;
    assign bus.cmd_len      = cmd_len_q;
    assign bus.rd_done      = rd_done_q;
    assign bus.wr_done      = wr_done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_axi_dma_scheduler.sv
// Directed bench for axi_dma_scheduler: a burst-splitting model fills a command
// scoreboard and a completion queue that are drained as the scheduler responds.
module tb_axi_dma_scheduler;
    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        last;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    cmd_t cmds[$];
    logic dirs[$];

    axi_dma_scheduler_if bus ();

    axi_dma_scheduler dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference burst splitter: min(remaining, 256, beats left in the 4 KB page)
    function automatic void model(input logic w, input logic [31:0] addr, input int unsigned beats);
        logic [31:0] a;
        int unsigned rem, page, b;
        a   = addr & 32'hFFFF_FFE0;
        rem = beats;
        dirs.push_back(w);
        while (rem != 0) begin
            page = (32'd4096 - 32'(a[11:0])) / 32;
            b    = rem;
            if (b > 256) b = 256;
            if (b > page) b = page;
            cmds.push_back(cmd_t'{w, a, 8'(b - 1), (rem == b)});
            a   = a + 32'(b * 32);
            rem = rem - b;
        end
    endfunction

    task automatic drive_req(input logic w, input logic [31:0] addr, input logic [19:0] beats);
        if (w) begin
            bus.wr_req_valid = 1'b1;
            bus.wr_req_addr  = addr;
            bus.wr_req_beats = beats;
        end else begin
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr  = addr;
            bus.rd_req_beats = beats;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'(0));
        check({tag, "_cmd_is_write"}, 64'(bus.cmd_is_write), 64'(0));
        check({tag, "_cmd_addr"}, 64'(bus.cmd_addr), 64'(0));
        check({tag, "_cmd_len"}, 64'(bus.cmd_len), 64'(0));
        check({tag, "_dones"}, 64'({bus.rd_done, bus.wr_done}), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_readies"}, 64'({bus.rd_req_ready, bus.wr_req_ready}), 64'(0));
    endtask

    // Acts as requesters + AXI side until n_dones transfers complete
    task automatic serve(input int n_dones, input int max_cycles);
        int   lat      = 0;
        int   done_at  = -1;
        int   dones    = 0;
        logic cur_last = 1'b0;
        logic rd_hs    = 1'b0;
        logic wr_hs    = 1'b0;
        logic fin      = 1'b0;
        cmd_t e;
        logic w;
        #1;
        for (int c = 0; c < max_cycles && !fin; c++) begin
            bus.burst_done = 1'b0;
            if (rd_hs) begin bus.rd_req_valid = 1'b0; rd_hs = 1'b0; end
            if (wr_hs) begin bus.wr_req_valid = 1'b0; wr_hs = 1'b0; end
            if (bus.rd_req_valid && bus.wr_req_valid)
                check("ready_exclusive", 64'(bus.rd_req_ready & bus.wr_req_ready), 64'(0));
            if (bus.rd_req_valid && bus.rd_req_ready) begin
                rd_hs = 1'b1;
                if (bus.rd_req_beats == 0) done_at = c + 2;
            end
            if (bus.wr_req_valid && bus.wr_req_ready) begin
                wr_hs = 1'b1;
                if (bus.wr_req_beats == 0) done_at = c + 2;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (cmds.size() == 0) begin
                    check("cmd_unexpected", 64'(cmds.size()), 64'(1));
                end else begin
                    e = cmds.pop_front();
                    check("cmd", 64'({bus.cmd_is_write, bus.cmd_addr, bus.cmd_len}),
                          64'({e.w, e.addr, e.len}));
                    cur_last = e.last;
                    lat      = 3;
                end
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    bus.burst_done = 1'b1;
                    if (cur_last) done_at = c + 2;
                end
            end
            if (c == done_at) begin
                if (dirs.size() == 0) begin
                    check("done_unexpected", 64'(dirs.size()), 64'(1));
                end else begin
                    w = dirs.pop_front();
                    check("done", 64'({bus.rd_done, bus.wr_done}), w ? 64'(1) : 64'(2));
                end
                check("busy_after_done", 64'(bus.busy), 64'(0));
                dones++;
                done_at = -1;
            end else if (bus.rd_done || bus.wr_done) begin
                check("spurious_done", 64'({bus.rd_done, bus.wr_done}), 64'(0));
            end
            if (dones == n_dones && cmds.size() == 0) fin = 1'b1;
            else tick();
        end
        bus.burst_done = 1'b0;
        check("serve_timeout", 64'(fin), 64'(1));
        tick();
        check("done_width", 64'({bus.rd_done, bus.wr_done}), 64'(0));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_addr  = '0;
        bus.rd_req_beats = '0;
        bus.wr_req_valid = 1'b0;
        bus.wr_req_addr  = '0;
        bus.wr_req_beats = '0;
        bus.cmd_ready    = 1'b1;
        bus.burst_done   = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Tie from reset: read first, then write; second tie also read first
        for (int r = 0; r < 2; r++) begin
            model(1'b0, 32'h0, 16);
            model(1'b1, 32'h8000, 16);
            drive_req(1'b0, 32'h0, 20'd16);
            drive_req(1'b1, 32'h8000, 20'd16);
            serve(2, 100);
        end

        // Single 64-beat read
        model(1'b0, 32'h0, 64);
        drive_req(1'b0, 32'h0, 20'd64);
        serve(1, 60);

        // Page-boundary split
        model(1'b0, 32'h1000_0F00, 300);
        drive_req(1'b0, 32'h1000_0F00, 20'd300);
        serve(1, 100);

        // Unaligned write one beat before a page edge
        model(1'b1, 32'h0000_0FE7, 5);
        drive_req(1'b1, 32'h0000_0FE7, 20'd5);
        serve(1, 60);

        // Write wrapping past the top of the address space
        model(1'b1, 32'hFFFF_FFE0, 2);
        drive_req(1'b1, 32'hFFFF_FFE0, 20'd2);
        serve(1, 60);

        // Command backpressure with a stray burst_done during ISSUE
        bus.cmd_ready = 1'b0;
        model(1'b0, 32'h2040, 200);
        drive_req(1'b0, 32'h2040, 20'd200);
        tick();
        bus.rd_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(bus.cmd_valid), 64'(1));
            check("stall_addr", 64'(bus.cmd_addr), 64'h2040);
            check("stall_len", 64'(bus.cmd_len), 64'(125));
            check("stall_is_write", 64'(bus.cmd_is_write), 64'(0));
            bus.burst_done = (i == 2);
            tick();
        end
        bus.burst_done = 1'b0;
        bus.cmd_ready  = 1'b1;
        serve(1, 100);

        // Zero-beat write
        model(1'b1, 32'h4000, 0);
        drive_req(1'b1, 32'h4000, 20'd0);
        serve(1, 20);

        // Reset while a burst is outstanding
        drive_req(1'b0, 32'h0, 20'd300);
        tick();
        bus.rd_req_valid = 1'b0;
        tick();
        tick();
        check("wait_busy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        tick();
        check_quiet("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.burst_done = (i == 1);
            tick();
            check("post_reset_dones", 64'({bus.rd_done, bus.wr_done}), 64'(0));
            check("post_reset_busy", 64'(bus.busy), 64'(0));
        end
        bus.burst_done = 1'b0;
        model(1'b0, 32'h1000_0000, 20);
        drive_req(1'b0, 32'h1000_0000, 20'd20);
        serve(1, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
